// File: rtl/overdrive_voice_scheduler_pkg.sv
// Shared types and constants for the overdrive voice scheduler slice.
package overdrive_pkg;

    localparam int unsigned DATA_W_DEF     = 31;
    localparam int unsigned NUM_VOICES_DEF = 4;

    typedef enum logic {
        ST_SERVE  = 1'b0,
        ST_DIVIDE = 1'b1
    } state_t;

    typedef logic [$clog2(NUM_VOICES_DEF)-1:0] voice_t;

    localparam logic [DATA_W_DEF-1:0] GAIN_UNITY = DATA_W_DEF'(1);

endpackage

// File: rtl/overdrive_voice_scheduler_if.sv
// Voice request / shaped-result bus between the voices and the shared overdrive datapath.
interface overdrive_voice_scheduler_if #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned DATA_W     = 31
) ();

    logic [NUM_VOICES-1:0]         req_valid;
    logic [NUM_VOICES*DATA_W-1:0]  req_amplitude;
    logic [NUM_VOICES-1:0]         req_ready;
    logic                          out_valid;
    logic [$clog2(NUM_VOICES)-1:0] out_voice;
    logic [DATA_W-1:0]             out_amplitude;

    modport master (
        output req_valid, req_amplitude,
        input  req_ready, out_valid, out_voice, out_amplitude
    );

    modport slave (
        input  req_valid, req_amplitude,
        output req_ready, out_valid, out_voice, out_amplitude
    );

endinterface

// File: rtl/overdrive_voice_scheduler_od_gain_divider.sv
// Restoring divider: one quotient bit per cycle, DATA_W cycles; start while busy restarts it.
module od_gain_divider
    import overdrive_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              last,
    output logic [DATA_W-1:0] quotient
);

    localparam int unsigned CW = $clog2(DATA_W + 1);

    logic [CW-1:0]     count;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvs;
    logic [DATA_W:0]   rem_shift;
    logic [DATA_W:0]   rem_sub;
    logic              fits;

    // quo starts as the dividend and is shifted out MSB-first while quotient bits shift in
    always_comb begin
        rem_shift = {rem, quo[DATA_W-1]};
        rem_sub   = rem_shift - {1'b0, dvs};
        fits      = (rem_shift >= {1'b0, dvs});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
        end else if (start) begin
            count <= CW'(DATA_W);
            rem   <= '0;
            quo   <= dividend;
            dvs   <= divisor;
        end else if (count != '0) begin
            count <= count - 1'b1;
            if (fits) begin
                rem <= rem_sub[DATA_W-1:0];
                quo <= {quo[DATA_W-2:0], 1'b1};
            end else begin
                rem <= rem_shift[DATA_W-1:0];
                quo <= {quo[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        busy     = (count != '0);
        last     = (count == CW'(1));
        quotient = quo;
    end

endmodule

// File: rtl/overdrive_voice_scheduler.sv
// Round-robin sharing of one clip-and-gain overdrive datapath among NUM_VOICES voices.
// Define OVERDRIVE_SAT_EN to saturate the product instead of wrapping it.
module overdrive_voice_scheduler
    import overdrive_pkg::*;
#(
    parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_load,
    input  logic                     activate,
    input  logic                     overdrive,
    input  logic [DATA_W-1:0]        threshold,
    input  logic [DATA_W-1:0]        max_amplitude,
    output logic                     cfg_busy,
    overdrive_voice_scheduler_if.slave bus
);

    localparam int unsigned      VW    = $clog2(NUM_VOICES);
    localparam logic [DATA_W-1:0] UNITY = DATA_W'(GAIN_UNITY);

    state_t            state, state_next;
    logic              act_q;
    logic [DATA_W-1:0] thr_q;
    logic              use_div_q;
    logic              divide_req;
    logic              grant_en;
    logic              div_busy;
    logic              div_last;
    logic [DATA_W-1:0] div_quotient;
    logic [DATA_W-1:0] gain;

    logic [VW-1:0]     ptr;
    logic [VW-1:0]     sel;
    logic              found;
    logic              xfer;
    logic [DATA_W-1:0] amp;
    logic [DATA_W-1:0] clip;
    logic [DATA_W-1:0] shaped;
    logic [DATA_W-1:0] result;

    assign divide_req = overdrive && (threshold != '0);

    od_gain_divider #(.DATA_W(DATA_W)) u_div (
        .clk      (clk),
        .rst_n    (reset),
        .start    (cfg_load && divide_req),
        .dividend (max_amplitude),
        .divisor  (threshold),
        .busy     (div_busy),
        .last     (div_last),
        .quotient (div_quotient)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_SERVE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (cfg_load)                                      state_next = divide_req ? ST_DIVIDE : ST_SERVE;
        else if (state == ST_DIVIDE && div_busy && div_last) state_next = ST_SERVE;
    end

    always_comb begin
        cfg_busy = (state == ST_DIVIDE);
        grant_en = (state == ST_SERVE) && !cfg_load;
    end

    // The divider's quotient register holds the gain once it finishes; it is only read in SERVE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_q     <= 1'b0;
            thr_q     <= '0;
            use_div_q <= 1'b0;
        end else if (cfg_load) begin
            act_q     <= activate;
            thr_q     <= threshold;
            use_div_q <= divide_req;
        end
    end

    assign gain = use_div_q ? div_quotient : UNITY;

    always_comb begin
        int unsigned j;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_VOICES) j = j - NUM_VOICES;
            if (!found && bus.req_valid[VW'(j)]) begin
                found = 1'b1;
                sel   = VW'(j);
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (grant_en && found) bus.req_ready[sel] = 1'b1;
        xfer = grant_en && found;
    end

    always_comb begin
        amp  = bus.req_amplitude[int'(sel)*DATA_W +: DATA_W];
        clip = (amp > thr_q) ? thr_q : amp;
`ifdef OVERDRIVE_SAT_EN
        begin
            logic [2*DATA_W-1:0] prod;
            prod   = {{DATA_W{1'b0}}, clip} * {{DATA_W{1'b0}}, gain};
            shaped = (prod[2*DATA_W-1:DATA_W] != '0) ? '1 : prod[DATA_W-1:0];
        end
`else
        shaped = DATA_W'(clip * gain);
`endif
        result = act_q ? shaped : amp;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr               <= '0;
            bus.out_valid     <= 1'b0;
            bus.out_voice     <= '0;
            bus.out_amplitude <= '0;
        end else begin
            bus.out_valid <= xfer;
            if (xfer) begin
                ptr               <= (sel == VW'(NUM_VOICES - 1)) ? '0 : sel + 1'b1;
                bus.out_voice     <= sel;
                bus.out_amplitude <= result;
            end
        end
    end

endmodule

// File: tb/tb_overdrive_voice_scheduler.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor pops and compares.
module tb_overdrive_voice_scheduler;
    import overdrive_pkg::*;

    localparam int unsigned NV = 4;
    localparam int unsigned DW = 31;
    localparam logic [DW-1:0] AMAX = 31'h7FFF_FFFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_load;
    logic          activate;
    logic          overdrive;
    logic [DW-1:0] threshold;
    logic [DW-1:0] max_amplitude;
    logic          cfg_busy;

    overdrive_voice_scheduler_if #(.NUM_VOICES(NV), .DATA_W(DW)) bus ();

    overdrive_voice_scheduler #(.NUM_VOICES(NV), .DATA_W(DW)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_load      (cfg_load),
        .activate      (activate),
        .overdrive     (overdrive),
        .threshold     (threshold),
        .max_amplitude (max_amplitude),
        .cfg_busy      (cfg_busy),
        .bus           (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        voice_t        voice;
        logic [DW-1:0] amp;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic voice_t idx_of(input logic [NV-1:0] oh);
        voice_t r = '0;
        for (int i = 0; i < NV; i++) if (oh[i]) r = voice_t'(i);
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset === 1'b1 && bus.out_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                e = q.pop_front();
                check("out_voice", 64'(bus.out_voice), 64'(e.voice));
                check("out_amplitude", 64'(bus.out_amplitude), 64'(e.amp));
            end
        end
    end

    task automatic push_exp(input logic [NV-1:0] rdy, input logic [DW-1:0] amp);
        exp_t e;
        e.voice = idx_of(rdy);
        e.amp   = amp;
        q.push_back(e);
    endtask

    task automatic set_amp(input int v, input logic [DW-1:0] a);
        bus.req_amplitude[v*DW +: DW] = a;
    endtask

    task automatic step(input logic [NV-1:0] v, input logic [NV-1:0] rdy, input logic [DW-1:0] amp);
        bus.req_valid = v;
        @(negedge clk);
        check("req_ready", 64'(bus.req_ready), 64'(rdy));
        if (rdy != '0) push_exp(rdy, amp);
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic act, input logic od, input logic [DW-1:0] thr,
                       input logic [DW-1:0] mx, input logic [NV-1:0] rv);
        cfg_load      = 1'b1;
        activate      = act;
        overdrive     = od;
        threshold     = thr;
        max_amplitude = mx;
        bus.req_valid = rv;
        @(negedge clk);
        check("ready_in_cfg_cycle", 64'(bus.req_ready), 0);
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
    endtask

    task automatic wait_divide(input int exp_cycles, input logic [NV-1:0] rdy, input logic [DW-1:0] amp);
        int cnt = 0;
        bit granted = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cfg_busy !== 1'b1) break;
            cnt++;
            if (bus.req_ready !== '0) granted = 1'b1;
            @(posedge clk);
            #1;
        end
        check("busy_cycles", 64'(cnt), 64'(exp_cycles));
        check("no_grant_while_busy", 64'(granted), 0);
        check("grant_after_busy", 64'(bus.req_ready), 64'(rdy));
        if (rdy != '0) push_exp(rdy, amp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset             = 1'b0;
        cfg_load          = 1'b0;
        activate          = 1'b0;
        overdrive         = 1'b0;
        threshold         = '0;
        max_amplitude     = '0;
        bus.req_valid     = '0;
        bus.req_amplitude = '0;

        #12;
        check("rst_cfg_busy", 64'(cfg_busy), 0);
        check("rst_out_valid", 64'(bus.out_valid), 0);
        check("rst_out_voice", 64'(bus.out_voice), 0);
        check("rst_out_amplitude", 64'(bus.out_amplitude), 0);
        check("rst_req_ready", 64'(bus.req_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 1: bypass after reset
        set_amp(2, 1234);
        step(4'b0100, 4'b0100, 1234);
        step(4'b0000, 4'b0000, 0);

        // 2: divide 4000/1000 -> gain 4
        set_amp(0, 500);
        set_amp(1, 1500);
        set_amp(2, 1500);
        set_amp(3, 1500);
        cfg(1'b1, 1'b1, 1000, 4000, 4'b1111);
        wait_divide(31, 4'b1000, 4000);
        step(4'b0001, 4'b0001, 2000);
        step(4'b0000, 4'b0000, 0);

        // 3: clip only, skip path
        set_amp(2, 999);
        cfg(1'b1, 1'b0, 1000, 0, 4'b0010);
        wait_divide(0, 4'b0010, 1000);
        step(4'b0100, 4'b0100, 999);
        step(4'b0000, 4'b0000, 0);

        // 4: round-robin ordering
        set_amp(0, 10);
        set_amp(1, 20);
        set_amp(2, 30);
        set_amp(3, 40);
        step(4'b1000, 4'b1000, 40);
        step(4'b1111, 4'b0001, 10);
        step(4'b1111, 4'b0010, 20);
        step(4'b1111, 4'b0100, 30);
        step(4'b1111, 4'b1000, 40);
        step(4'b1111, 4'b0001, 10);
        step(4'b1101, 4'b0100, 30);
        step(4'b1101, 4'b1000, 40);
        step(4'b1101, 4'b0001, 10);
        step(4'b1101, 4'b0100, 30);
        step(4'b0000, 4'b0000, 0);

        // 5: restart mid-divide, gain 9000/3000 = 3
        set_amp(3, 2000);
        set_amp(0, 5000);
        cfg(1'b1, 1'b1, 1000, 2000, 4'b0000);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("busy_before_restart", 64'(cfg_busy), 1);
            @(posedge clk);
            #1;
        end
        cfg(1'b1, 1'b1, 3000, 9000, 4'b1111);
        wait_divide(31, 4'b1000, 6000);
        step(4'b0001, 4'b0001, 9000);
        step(4'b0000, 4'b0000, 0);

        // 6: full-scale gain, amp clipped to threshold 1
        set_amp(1, 5);
        cfg(1'b1, 1'b1, 1, AMAX, 4'b0010);
        wait_divide(31, 4'b0010, AMAX);
        step(4'b0000, 4'b0000, 0);

        // async reset mid-divide
        cfg(1'b1, 1'b1, 1000, 4000, 4'b0000);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        check("midreset_cfg_busy", 64'(cfg_busy), 0);
        check("midreset_out_valid", 64'(bus.out_valid), 0);
        check("midreset_out_voice", 64'(bus.out_voice), 0);
        check("midreset_out_amplitude", 64'(bus.out_amplitude), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        set_amp(2, 77);
        step(4'b0100, 4'b0100, 77);
        step(4'b0000, 4'b0000, 0);
        step(4'b0000, 4'b0000, 0);

        check("scoreboard_drained", 64'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
